multicycle_divider: RTL and testbench
=====================================

Name: multicycle_divider

Overview:
- Parametrised iterative restoring divider; successor to the 32-bit single-mode divider in the MIPS32 core's HI/LO unit.
- Adds configurable operand width and bits-per-cycle, a completion pulse, an explicit cancel, a divide-by-zero flag, and MIPS-correct remainder sign (remainder sign follows the dividend).

Parameters:
- WIDTH, 32, operand/result width; even, >= 4.
- BITS_PER_CYCLE, 1, quotient bits resolved per iteration; legal values 1 or 2; WIDTH must be divisible by it.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- OP_div  input  1  start signed divide; captures operands this cycle.
- OP_divu  input  1  start unsigned divide; captures operands this cycle.
- Cancel  input  1  abort any running operation.
- Dividend  input  WIDTH  numerator.
- Divisor  input  WIDTH  denominator.
- Quotient  output  WIDTH  sign-corrected quotient; valid from the Done cycle until the next start.
- Remainder  output  WIDTH  sign-corrected remainder; same validity as Quotient.
- Stall  output  1  high while iterating.
- Done  output  1  one-cycle pulse when results become valid.
- DivZero  output  1  Divisor was zero for the last completed operation; held with the results.

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE; Quotient=0, Remainder=0, Stall=0, Done=0, DivZero=0, cycle counter=0. Reset overrides all inputs, including mid-operation.
- States: IDLE -> RUN on start; RUN -> DONE after N = WIDTH/BITS_PER_CYCLE iterations; DONE -> IDLE after 1 cycle, or -> RUN on start.
- Start = OP_div | OP_divu. OP_div has priority if both are high.
- Capture on start:
  - Signed: magnitudes of both operands; neg_q = Dividend[MSB] ^ Divisor[MSB]; neg_r = Dividend[MSB].
  - Unsigned: raw operands; neg_q = neg_r = 0.
  - Running remainder cleared; div_zero = (Divisor == 0).
- Iteration: each RUN cycle performs BITS_PER_CYCLE restoring steps, each a (WIDTH+1)-bit trial subtract of the shifted remainder minus the divisor. Non-negative result: keep difference, shift in quotient bit 1; negative: keep shifted remainder, shift in 0.
- Timing: Stall=1 for exactly N cycles, starting the cycle after start. Done=1 and Stall=0 on the cycle after the last iteration edge. Latency from start cycle to Done cycle is N+1.
- Outputs: Quotient = neg_q ? -q : q; Remainder = neg_r ? -r : r; both driven from registers, all arithmetic modulo 2^WIDTH.
- Signed overflow (MIN / -1): Quotient=MIN, Remainder=0, no flag.
- Divide by zero: DivZero=1, Quotient=all ones, Remainder=Dividend (raw input, no sign fix), regardless of mode.
- Start during RUN or DONE: current operation is discarded with no Done for it, and a new operation starts.
- Cancel in RUN (no start same cycle): -> IDLE next edge, Stall=0, no Done, Quotient/Remainder/DivZero keep the previous completed values. Start together with Cancel: start wins. Cancel in IDLE/DONE: no effect.
- Counter width is $clog2(N)+1; the counter never wraps while in RUN.

Optional Feature:
- Macro: DIVIDER_ZERO_FASTPATH_EN.
- Defined: a start with Divisor==0 skips RUN. Done, DivZero=1 and the divide-by-zero results appear the next cycle; Stall stays 0.
- Undefined: a zero divisor iterates the full N cycles, with the divide-by-zero result values forced at completion.
- Result values are identical either way; only latency and Stall differ.

Decomposition:
- Package divider_pkg:
  - state enum {DIV_IDLE, DIV_RUN, DIV_DONE};
  - op enum {DIV_OP_NONE, DIV_OP_SIGNED, DIV_OP_UNSIGNED};
  - function for two's-complement magnitude.
- Sub-module divider_step: combinational single restoring step (remainder, quotient shift register, divisor in; updated remainder and quotient out), instantiated BITS_PER_CYCLE times in a chain.

Test Plan:
- WIDTH=32, BPC=1, OP_divu 100/7 -> Stall high 32 cycles, Done pulse at cycle 33, Quotient=14, Remainder=2, DivZero=0.
- OP_div -100/7 -> Q=0xFFFFFFF2, R=0xFFFFFFFE. OP_div 100/-7 -> Q=0xFFFFFFF2, R=2. OP_div -100/-7 -> Q=14, R=0xFFFFFFFE.
- OP_div 0x80000000 / 0xFFFFFFFF -> Q=0x80000000, R=0, DivZero=0. OP_divu 0xFFFFFFFF/1 -> Q=0xFFFFFFFF, R=0.
- OP_divu 5/0 -> DivZero=1, Q=0xFFFFFFFF, R=5. Done after 33 cycles without the macro; next cycle with it.
- Start 1000/3, then Cancel at iteration 10 -> Stall low next cycle, no Done, outputs unchanged. Start 9/2, then OP_divu 50/5 at iteration 5 -> a single Done, Q=10, R=0.
- reset=0 at iteration 20 -> all outputs 0 next edge. BPC=2, OP_divu 100/7 -> Stall 16 cycles, Q=14, R=2.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_e;

    typedef enum logic [1:0] {
        DIV_OP_NONE,
        DIV_OP_SIGNED,
        DIV_OP_UNSIGNED
    } div_op_e;

    localparam int DIV_MAX_W = 64;

    // Caller sign-extends to DIV_MAX_W and truncates back; MIN maps to itself.
    function automatic logic [DIV_MAX_W-1:0] twos_mag(input logic [DIV_MAX_W-1:0] x);
        return x[DIV_MAX_W-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr_i};

    // quo_i doubles as the dividend shift register; quotient bits enter at the LSB.
    assign rem_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/multicycle_divider.sv
// Iterative signed/unsigned restoring divider, BITS_PER_CYCLE steps per clock.
// Optional DIVIDER_ZERO_FASTPATH_EN: a zero divisor completes the cycle after start.
module multicycle_divider
    import divider_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             OP_div,
    input  logic             OP_divu,
    input  logic             Cancel,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Stall,
    output logic             Done,
    output logic             DivZero
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, dvd_raw_q;
    logic             neg_q_q, neg_r_q, dz_q;
    logic [WIDTH-1:0] quo_out_q, rem_out_q;
    logic             stall_q, done_q, divzero_q;

    div_op_e          op_d;
    logic             start;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] rem_d, quo_d, quo_fix, rem_fix;

    always_comb begin
        op_d = DIV_OP_NONE;
        if (OP_div)       op_d = DIV_OP_SIGNED;
        else if (OP_divu) op_d = DIV_OP_UNSIGNED;
    end

    assign start   = (op_d != DIV_OP_NONE);
    assign dvd_mag = WIDTH'(twos_mag(DIV_MAX_W'($signed(Dividend))));
    assign dvs_mag = WIDTH'(twos_mag(DIV_MAX_W'($signed(Divisor))));

    logic [WIDTH-1:0] rem_c [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] quo_c [BITS_PER_CYCLE+1];

    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        divider_step #(.WIDTH(WIDTH)) u_step (
            .rem_i  (rem_c[g]),
            .quo_i  (quo_c[g]),
            .dvsr_i (dvsr_q),
            .rem_o  (rem_c[g+1]),
            .quo_o  (quo_c[g+1])
        );
    end

    assign rem_d   = rem_c[BITS_PER_CYCLE];
    assign quo_d   = quo_c[BITS_PER_CYCLE];
    assign quo_fix = neg_q_q ? (~quo_d + 1'b1) : quo_d;
    assign rem_fix = neg_r_q ? (~rem_d + 1'b1) : rem_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            dvd_raw_q <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            dz_q      <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            stall_q   <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                // A start always wins: any running or finished op is dropped.
                rem_q     <= '0;
                cnt_q     <= '0;
                dvd_raw_q <= Dividend;
                dz_q      <= (Divisor == '0);
                if (op_d == DIV_OP_SIGNED) begin
                    quo_q   <= dvd_mag;
                    dvsr_q  <= dvs_mag;
                    neg_q_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                    neg_r_q <= Dividend[WIDTH-1];
                end else begin
                    quo_q   <= Dividend;
                    dvsr_q  <= Divisor;
                    neg_q_q <= 1'b0;
                    neg_r_q <= 1'b0;
                end
`ifdef DIVIDER_ZERO_FASTPATH_EN
                if (Divisor == '0) begin
                    state_q   <= DIV_DONE;
                    stall_q   <= 1'b0;
                    done_q    <= 1'b1;
                    divzero_q <= 1'b1;
                    quo_out_q <= '1;
                    rem_out_q <= Dividend;
                end else begin
                    state_q <= DIV_RUN;
                    stall_q <= 1'b1;
                end
`else
                state_q <= DIV_RUN;
                stall_q <= 1'b1;
`endif
            end else begin
                case (state_q)
                    DIV_RUN: begin
                        if (Cancel) begin
                            state_q <= DIV_IDLE;
                            stall_q <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            rem_q <= rem_d;
                            quo_q <= quo_d;
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == LAST) begin
                                state_q   <= DIV_DONE;
                                stall_q   <= 1'b0;
                                done_q    <= 1'b1;
                                cnt_q     <= '0;
                                divzero_q <= dz_q;
                                quo_out_q <= dz_q ? '1 : quo_fix;
                                rem_out_q <= dz_q ? dvd_raw_q : rem_fix;
                            end
                        end
                    end
                    DIV_DONE: state_q <= DIV_IDLE;
                    default:  state_q <= DIV_IDLE;
                endcase
            end
        end
    end

    assign Quotient  = quo_out_q;
    assign Remainder = rem_out_q;
    assign Stall     = stall_q;
    assign Done      = done_q;
    assign DivZero   = divzero_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Directed bench: one WIDTH=32 divider at 1 and one at 2 bits per cycle, same stimulus.
module tb_multicycle_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, op_div, op_divu, cancel;
    logic [31:0] dvd, dvs;
    logic [31:0] q1, r1, q2, r2;
    logic        st1, dn1, dz1, st2, dn2, dz2;

    multicycle_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .clock(clk), .reset(rst_n), .OP_div(op_div), .OP_divu(op_divu), .Cancel(cancel),
        .Dividend(dvd), .Divisor(dvs), .Quotient(q1), .Remainder(r1),
        .Stall(st1), .Done(dn1), .DivZero(dz1)
    );

    multicycle_divider #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (
        .clock(clk), .reset(rst_n), .OP_div(op_div), .OP_divu(op_divu), .Cancel(cancel),
        .Dividend(dvd), .Divisor(dvs), .Quotient(q2), .Remainder(r2),
        .Stall(st2), .Done(dn2), .DivZero(dz2)
    );

    int ncmp = 0;
    int nerr = 0;
    int dcnt1, dcnt2, dcyc1, dcyc2, scnt1, scnt2;

`ifdef DIVIDER_ZERO_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        dcnt1 = 0; dcnt2 = 0; dcyc1 = 0; dcyc2 = 0; scnt1 = 0; scnt2 = 0;
    endtask

    // Sample at negedges; k is the cycle index counted from the start cycle.
    task automatic mon(input int n);
        for (int k = 1; k <= n; k++) begin
            if (dn1) begin dcnt1++; if (dcyc1 == 0) dcyc1 = k; end
            if (dn2) begin dcnt2++; if (dcyc2 == 0) dcyc2 = k; end
            if (st1) scnt1++;
            if (st2) scnt2++;
            @(negedge clk);
        end
    endtask

    task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_div  = sgn;
        op_divu = !sgn;
        dvd     = a;
        dvs     = b;
        @(negedge clk);
        op_div  = 1'b0;
        op_divu = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] q, input logic [31:0] r, input bit dz);
        chk({tag, " Q bpc1"}, q1, q);
        chk({tag, " R bpc1"}, r1, r);
        chk({tag, " DZ bpc1"}, 32'(dz1), 32'(dz));
        chk({tag, " Q bpc2"}, q2, q);
        chk({tag, " R bpc2"}, r2, r);
        chk({tag, " DZ bpc2"}, 32'(dz2), 32'(dz));
    endtask

    logic [31:0] pq, pr;
    bit          pdz;
    bit          fastz;

    initial begin
        vt[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vt[1] = '{1'b1, -32'sd100,      32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
        vt[2] = '{1'b1, 32'd100,        -32'sd7,        32'hFFFFFFF2,   32'd2,          1'b0};
        vt[3] = '{1'b1, -32'sd100,      -32'sd7,        32'd14,         32'hFFFFFFFE,   1'b0};
        vt[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vt[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vt[6] = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1};
        vt[7] = '{1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
        vt[8] = '{1'b0, 32'hFFFFFFFF,   32'd10,         32'h19999999,   32'd5,          1'b0};
        vt[9] = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};

        rst_n = 1'b0; op_div = 1'b0; op_divu = 1'b0; cancel = 1'b0; dvd = '0; dvs = '0;
        repeat (2) @(negedge clk);
        chk_outs("reset", 32'd0, 32'd0, 1'b0);
        chk("reset stall", {30'd0, st1, st2}, 32'd0);
        chk("reset done", {30'd0, dn1, dn2}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            start_op(vt[i].sgn, vt[i].a, vt[i].b);
            clr();
            mon(40);
            fastz = FAST && vt[i].dz;
            chk_outs($sformatf("vec%0d", i), vt[i].q, vt[i].r, vt[i].dz);
            chk($sformatf("vec%0d done count bpc1", i), 32'(dcnt1), 32'd1);
            chk($sformatf("vec%0d done count bpc2", i), 32'(dcnt2), 32'd1);
            chk($sformatf("vec%0d done cycle bpc1", i), 32'(dcyc1), fastz ? 32'd1 : 32'd33);
            chk($sformatf("vec%0d done cycle bpc2", i), 32'(dcyc2), fastz ? 32'd1 : 32'd17);
            chk($sformatf("vec%0d stall cycles bpc1", i), 32'(scnt1), fastz ? 32'd0 : 32'd32);
            chk($sformatf("vec%0d stall cycles bpc2", i), 32'(scnt2), fastz ? 32'd0 : 32'd16);
            pq = vt[i].q; pr = vt[i].r; pdz = vt[i].dz;
        end

        // Cancel mid-run: no Done, previous results held.
        start_op(1'b0, 32'd1000, 32'd3);
        clr();
        mon(9);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel stall drop", {30'd0, st1, st2}, 32'd0);
        clr();
        mon(40);
        chk("cancel no done", 32'(dcnt1 + dcnt2), 32'd0);
        chk_outs("cancel hold", pq, pr, pdz);

        // Restart during RUN: only the second op completes.
        start_op(1'b0, 32'd9, 32'd2);
        clr();
        mon(4);
        start_op(1'b0, 32'd50, 32'd5);
        mon(40);
        chk("restart done count bpc1", 32'(dcnt1), 32'd1);
        chk("restart done count bpc2", 32'(dcnt2), 32'd1);
        chk_outs("restart", 32'd10, 32'd0, 1'b0);

        // Reset in the middle of an operation.
        start_op(1'b1, -32'sd100, 32'd7);
        mon(19);
        rst_n = 1'b0;
        @(negedge clk);
        chk_outs("midreset", 32'd0, 32'd0, 1'b0);
        chk("midreset stall", {30'd0, st1, st2}, 32'd0);
        chk("midreset done", {30'd0, dn1, dn2}, 32'd0);
        rst_n = 1'b1;

        start_op(1'b0, 32'd100, 32'd7);
        clr();
        mon(40);
        chk_outs("post-reset", 32'd14, 32'd2, 1'b0);
        chk("post-reset done cycle bpc1", 32'(dcyc1), 32'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
